// File: rtl/rv_pkg.sv
// rv_pkg: shared RISC-V decode definitions.
//   - 5-bit major opcode constants (inst[6:2])
//   - funct3 constants for SYSTEM / CSR forms
//   - decoded_t: one decoded instruction. The immediate is held at IMM_W bits,
//     the widest legal XLEN; a stage built for a narrower XLEN keeps the low
//     XLEN bits, which are already a correct sign extension.
package rv_pkg;

   localparam int IMM_W = 64;

   localparam logic [4:0] LOAD      = 5'b00000;
   localparam logic [4:0] MISC_MEM  = 5'b00011;
   localparam logic [4:0] OP_IMM    = 5'b00100;
   localparam logic [4:0] AUIPC     = 5'b00101;
   localparam logic [4:0] OP_IMM_32 = 5'b00110;
   localparam logic [4:0] STORE     = 5'b01000;
   localparam logic [4:0] OP        = 5'b01100;
   localparam logic [4:0] LUI       = 5'b01101;
   localparam logic [4:0] OP_32     = 5'b01110;
   localparam logic [4:0] BRANCH    = 5'b11000;
   localparam logic [4:0] JALR      = 5'b11001;
   localparam logic [4:0] JAL       = 5'b11011;
   localparam logic [4:0] SYSTEM    = 5'b11100;

   localparam logic [2:0] F3_PRIV   = 3'b000;  // ecall / ebreak
   localparam logic [2:0] F3_CSRRW  = 3'b001;
   localparam logic [2:0] F3_CSRRS  = 3'b010;
   localparam logic [2:0] F3_CSRRC  = 3'b011;
   localparam logic [2:0] F3_SYSRSV = 3'b100;  // reserved, illegal
   localparam logic [2:0] F3_CSRRWI = 3'b101;
   localparam logic [2:0] F3_CSRRSI = 3'b110;
   localparam logic [2:0] F3_CSRRCI = 3'b111;

   typedef struct packed {
      logic             sigill;
      logic [4:0]       opcode;
      logic [2:0]       funct3;
      logic [6:0]       funct7;
      logic [4:0]       funct5;
      logic [4:0]       rd;
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [11:0]      csr;
      logic             csr_load;
      logic             csr_store;
      logic [4:0]       csrimm;
      logic [IMM_W-1:0] imm;
   } decoded_t;

   function automatic logic [IMM_W-1:0] sext12(input logic [11:0] v);
      return {{(IMM_W-12){v[11]}}, v};
   endfunction

endpackage

// File: rtl/rv_decode_comb.sv
// rv_decode_comb: purely combinational RV32I/RV64I decoder.
//   inst : raw 32-bit instruction
//   dec  : decoded fields; unused fields are 0, and an illegal instruction
//          keeps only opcode and funct3 with sigill set.
module rv_decode_comb
   import rv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0] inst,
   output decoded_t    dec
);

   localparam bit RV64 = (XLEN == 64);

   logic [2:0]       f3;
   logic [4:0]       rd_f, rs1_f, rs2_f;
   logic [IMM_W-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic             ill;

   assign f3    = inst[14:12];
   assign rd_f  = inst[11:7];
   assign rs1_f = inst[19:15];
   assign rs2_f = inst[24:20];

   assign imm_i = sext12(inst[31:20]);
   assign imm_s = sext12({inst[31:25], inst[11:7]});
   assign imm_b = {{(IMM_W-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u = {{(IMM_W-32){inst[31]}}, inst[31:12], 12'b0};
   assign imm_j = {{(IMM_W-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

   always_comb begin
      dec        = '0;
      ill        = 1'b0;
      dec.opcode = inst[6:2];
      dec.funct3 = f3;
      case (inst[6:2])
         LOAD: begin
            ill     = (f3 == 3'b111) || (!RV64 && (f3 == 3'b011 || f3 == 3'b110));
            dec.rd  = rd_f;
            dec.rs1 = rs1_f;
            dec.imm = imm_i;
         end
         MISC_MEM: begin
            dec.rd  = rd_f;
            dec.rs1 = rs1_f;
            dec.imm = imm_i;
         end
         OP_IMM: begin
            // RV32 shamt is 5 bits: inst[25] set is a 6-bit shamt
            ill     = !RV64 && (f3 == 3'b001 || f3 == 3'b101) && inst[25];
            dec.rd  = rd_f;
            dec.rs1 = rs1_f;
            dec.imm = imm_i;
         end
         OP_IMM_32: begin
            ill     = !RV64;
            dec.rd  = rd_f;
            dec.rs1 = rs1_f;
            dec.imm = imm_i;
         end
         JALR: begin
            ill     = (f3 != 3'b000);
            dec.rd  = rd_f;
            dec.rs1 = rs1_f;
            dec.imm = imm_i;
         end
         STORE: begin
            ill     = f3[2] || (!RV64 && f3 == 3'b011);
            dec.rs1 = rs1_f;
            dec.rs2 = rs2_f;
            dec.imm = imm_s;
         end
         BRANCH: begin
            ill     = (f3[2:1] == 2'b01);
            dec.rs1 = rs1_f;
            dec.rs2 = rs2_f;
            dec.imm = imm_b;
         end
         LUI, AUIPC: begin
            dec.funct3 = 3'b000;
            dec.rd     = rd_f;
            dec.imm    = imm_u;
         end
         JAL: begin
            dec.funct3 = 3'b000;
            dec.rd     = rd_f;
            dec.imm    = imm_j;
         end
         OP, OP_32: begin
            ill        = (inst[6:2] == OP_32) && !RV64;
            dec.rd     = rd_f;
            dec.rs1    = rs1_f;
            dec.rs2    = rs2_f;
            dec.funct7 = inst[31:25];
            dec.funct5 = inst[31:27];
         end
         SYSTEM: begin
            if (f3 == F3_PRIV) begin
               // ecall/ebreak told apart by the I-immediate
               dec.imm = imm_i;
            end else if (f3 == F3_SYSRSV) begin
               ill = 1'b1;
            end else begin
               dec.csr = inst[31:20];
               dec.rd  = rd_f;
               if (f3[2]) dec.csrimm = rs1_f;
               else       dec.rs1    = rs1_f;
               // rw forms skip the read when rd=x0; set/clear skip the
               // write when the source (register or zimm) is 0
               if (f3[1:0] == F3_CSRRW[1:0]) begin
                  dec.csr_load  = |rd_f;
                  dec.csr_store = 1'b1;
               end else begin
                  dec.csr_load  = 1'b1;
                  dec.csr_store = |rs1_f;
               end
            end
         end
         default: ill = 1'b1;
      endcase
      if (inst[1:0] != 2'b11) ill = 1'b1;
      if (ill) begin
         dec        = '0;
         dec.opcode = inst[6:2];
         dec.funct3 = f3;
      end
      dec.sigill = ill;
   end

endmodule

// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered decode stage with a 2-entry elastic buffer.
//   clock, reset        : clock, synchronous active-high reset
//   flush               : drop every held beat and the beat presented now
//   in_valid/in_ready   : upstream handshake; in_ready is a plain register
//   in_inst, in_pc      : raw instruction and its PC
//   out_valid/out_ready : downstream handshake
//   out_pc, sigill, opcode, funct3/7/5, rd, rs1, rs2, csr, csr_load,
//   csr_store, imm, csrimm : decoded beat from the main entry
// The main entry drives the outputs; the skid entry catches a beat accepted
// while main is full and stalled, so in_ready can be registered.
module rv_decode_stage
   import rv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic            sigill,
   output logic [4:0]      opcode,
   output logic [2:0]      funct3,
   output logic [6:0]      funct7,
   output logic [4:0]      funct5,
   output logic [4:0]      rd,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [11:0]     csr,
   output logic            csr_load,
   output logic            csr_store,
   output logic [XLEN-1:0] imm,
   output logic [4:0]      csrimm
);

   if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
      $error("rv_decode_stage: XLEN must be 32 or 64");
   end

   decoded_t        dec;
   decoded_t        main_q, skid_q;
   logic [XLEN-1:0] main_pc, skid_pc;
   logic            main_vld, skid_vld, rdy_q;
   logic            main_vld_d, skid_vld_d;
   logic            ld_main_new, ld_main_skid, ld_skid;
   logic            acc, drain;

   rv_decode_comb #(.XLEN(XLEN)) u_dec (
      .inst (in_inst),
      .dec  (dec)
   );

   assign acc   = in_valid & rdy_q;
   assign drain = main_vld & out_ready;

   // in_ready is low exactly when skid is full, so accept never coincides
   // with a skid->main move.
   always_comb begin
      main_vld_d   = main_vld;
      skid_vld_d   = skid_vld;
      ld_main_new  = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      if (drain) begin
         if (skid_vld) begin
            ld_main_skid = 1'b1;
            skid_vld_d   = 1'b0;
         end else if (acc) begin
            ld_main_new = 1'b1;
         end else begin
            main_vld_d = 1'b0;
         end
      end else if (acc) begin
         if (main_vld) begin
            ld_skid    = 1'b1;
            skid_vld_d = 1'b1;
         end else begin
            ld_main_new = 1'b1;
            main_vld_d  = 1'b1;
         end
      end
      if (flush) begin
         main_vld_d   = 1'b0;
         skid_vld_d   = 1'b0;
         ld_main_new  = 1'b0;
         ld_main_skid = 1'b0;
         ld_skid      = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         main_q   <= '0;
         skid_q   <= '0;
         main_pc  <= '0;
         skid_pc  <= '0;
         main_vld <= 1'b0;
         skid_vld <= 1'b0;
         rdy_q    <= 1'b1;
      end else begin
         main_vld <= main_vld_d;
         skid_vld <= skid_vld_d;
         rdy_q    <= ~skid_vld_d;
         if (ld_main_new) begin
            main_q  <= dec;
            main_pc <= in_pc;
         end else if (ld_main_skid) begin
            main_q  <= skid_q;
            main_pc <= skid_pc;
         end
         if (ld_skid) begin
            skid_q  <= dec;
            skid_pc <= in_pc;
         end
      end
   end

   // Upper immediate bits are dropped when XLEN is narrower than IMM_W.
   logic unused_imm_hi;
   assign unused_imm_hi = ^main_q.imm;

   assign in_ready  = rdy_q;
   assign out_valid = main_vld;
   assign out_pc    = main_pc;
   assign sigill    = main_q.sigill;
   assign opcode    = main_q.opcode;
   assign funct3    = main_q.funct3;
   assign funct7    = main_q.funct7;
   assign funct5    = main_q.funct5;
   assign rd        = main_q.rd;
   assign rs1       = main_q.rs1;
   assign rs2       = main_q.rs2;
   assign csr       = main_q.csr;
   assign csr_load  = main_q.csr_load;
   assign csr_store = main_q.csr_store;
   assign imm       = main_q.imm[XLEN-1:0];
   assign csrimm    = main_q.csrimm;

endmodule
